// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose: the fetch buffer entry type and buffer sizing constants used by
//          fetch_unit and fetch_skid_fifo.
// Ports:   none (package).
package fetch_unit_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int FETCH_BUF_DEPTH = 2;
  // Wide enough to hold occupancy values 0..FETCH_BUF_DEPTH.
  localparam int FETCH_OCC_W = $clog2(FETCH_BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - 2-entry fetch buffer with same-cycle bypass when empty
//
// Purpose: holds returned {pc, inst} words so that decode stalls lose nothing.
//          When empty, a word being pushed is presented on the head outputs in
//          the same cycle.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   push           a returned word is available this cycle
//   push_data      the returned {pc, inst}
//   pop            head is consumed this cycle (only asserted while head_valid)
//   flush          discard everything, including this cycle's push
//   head_valid     head_data holds a live entry (stored or bypassed)
//   head_data      oldest entry, or push_data when empty; zero when nothing live
//   occupancy      number of stored entries (bypass not counted)
module fetch_skid_fifo
  import fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_valid,
  output fetch_entry_t           head_data,
  output logic [FETCH_OCC_W-1:0] occupancy
);

  localparam logic [FETCH_OCC_W-1:0] OCC_0 = FETCH_OCC_W'(0);
  localparam logic [FETCH_OCC_W-1:0] OCC_1 = FETCH_OCC_W'(1);
  localparam logic [FETCH_OCC_W-1:0] OCC_2 = FETCH_OCC_W'(2);

  // e0 is always the head slot; e1 sits behind it.
  fetch_entry_t           e0_q, e0_d;
  fetch_entry_t           e1_q, e1_d;
  logic [FETCH_OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occupancy  = occ_q;
    head_valid = (occ_q != OCC_0) || push;
    if (occ_q != OCC_0) begin
      head_data = e0_q;
    end else if (push) begin
      head_data = push_data;
    end else begin
      head_data = '0;
    end
  end

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    if (flush) begin
      occ_d = OCC_0;
    end else if (occ_q == OCC_0) begin
      // A push that is popped in the same cycle went straight through the bypass.
      if (push && !pop) begin
        e0_d  = push_data;
        occ_d = OCC_1;
      end
    end else if (occ_q == OCC_1) begin
      if (push && pop) begin
        e0_d = push_data;
      end else if (pop) begin
        occ_d = OCC_0;
      end else if (push) begin
        e1_d  = push_data;
        occ_d = OCC_2;
      end
    end else begin
      // Full: the issue credit guarantees no push arrives without a pop.
      if (pop) begin
        e0_d = e1_q;
        if (push) begin
          e1_d = push_data;
        end else begin
          occ_d = OCC_1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= OCC_0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, BRAM issue, skid buffer, halt
//
// Purpose: owns the fetch PC, issues reads to a 1-cycle-latency instruction
//          BRAM, buffers returns in fetch_skid_fifo and presents {pc, inst} to
//          decode. Handles redirects and halts permanently on an accepted stop.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   stall            decode hold; head is not consumed
//   redirect         control transfer taken; redirect_pc is the target
//   redirect_pc      target PC, low two bits ignored
//   stop_in          stop flag for the instruction on inst_out
//   imem_en          BRAM read enable
//   imem_addr        BRAM word address
//   imem_rdata       BRAM data, valid the cycle after imem_en
//   valid_out        pc_out/inst_out hold a live instruction
//   pc_out, inst_out head instruction (zero when not valid)
//   halted           fetch stopped until reset
//   inst_count       accepted-instruction counter
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stop_in,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               valid_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        inst_out,
  output logic               halted,
  output logic [31:0]        inst_count
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] inst_count_q, inst_count_d;
  logic        inflight_q, inflight_d;
  logic        halted_q, halted_d;
  logic        run_q, run_d;

  logic                   fifo_push;
  logic                   fifo_flush;
  logic                   head_valid;
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;
  logic [FETCH_OCC_W-1:0] occupancy;

  logic                   redirect_take;
  logic                   accept;
  logic                   stop_take;
  logic [FETCH_OCC_W:0]   occ_after;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // The FIFO sees the raw return; killing it is done through flush, which keeps
  // the accept/stop decision out of the bypass path (no combinational loop).
  assign fifo_push  = inflight_q && !halted_q;
  assign push_entry = '{pc: inflight_pc_q, inst: imem_rdata};

  fetch_skid_fifo u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (accept),
    .flush      (fifo_flush),
    .head_valid (head_valid),
    .head_data  (head_entry),
    .occupancy  (occupancy)
  );

  // Control and outputs.
  always_comb begin
    redirect_take = redirect && !halted_q;
    valid_out     = head_valid && !halted_q;
    accept        = valid_out && !stall && !redirect;
    stop_take     = accept && stop_in;
    fifo_flush    = redirect_take || stop_take;
    pc_out        = valid_out ? head_entry.pc   : 32'h0;
    inst_out      = valid_out ? head_entry.inst : 32'h0;
    // Entries held at the end of this cycle; one more read may be outstanding
    // only if that leaves a free slot for it next cycle.
    occ_after = {1'b0, occupancy} + (FETCH_OCC_W + 1)'(fifo_push)
              - (FETCH_OCC_W + 1)'(accept);
    // run_q keeps the BRAM idle during reset and the first cycle after it.
    imem_en   = run_q && !halted_q && !redirect
              && (occ_after <= (FETCH_OCC_W + 1)'(1));
    imem_addr  = fetch_pc_q[IMEM_AW+1:2];
    halted     = halted_q;
    inst_count = inst_count_q;
  end

  // Next state.
  always_comb begin
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_take) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (imem_en) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_en) begin
      inflight_pc_d = fetch_pc_q;
    end
    inflight_d   = imem_en && !stop_take;
    halted_d     = halted_q || stop_take;
    inst_count_d = inst_count_q + 32'(accept);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0;
      inst_count_q  <= 32'h0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inst_count_q  <= inst_count_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
      run_q         <= run_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stop_in;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        halted;
  logic [31:0] inst_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stop_in     (stop_in),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .valid_out   (valid_out),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .halted      (halted),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  // BRAM model: word i holds 32'h1000_0000 + i, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + {18'd0, imem_addr};
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        stop;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        een;
    logic        ehalt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic sp, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic een,
                              input logic eh, input logic [31:0] ecnt);
    vec_t v;
    v.stall = st; v.redirect = rd; v.rpc = rpc; v.stop = sp;
    v.ev = ev; v.epc = epc; v.einst = einst; v.een = een; v.ehalt = eh; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, sample mid-cycle, then advance one clock.
  task automatic run_vec(input vec_t v, input string tag);
    stall = v.stall; redirect = v.redirect; redirect_pc = v.rpc; stop_in = v.stop;
    #4;
    chk({tag, " valid_out"}, {31'd0, valid_out}, {31'd0, v.ev});
    chk({tag, " pc_out"}, pc_out, v.epc);
    chk({tag, " inst_out"}, inst_out, v.einst);
    chk({tag, " imem_en"}, {31'd0, imem_en}, {31'd0, v.een});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.ehalt});
    chk({tag, " inst_count"}, inst_count, v.ecnt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid_out"}, {31'd0, valid_out}, 32'd0);
    chk({tag, " pc_out"}, pc_out, 32'd0);
    chk({tag, " inst_out"}, inst_out, 32'd0);
    chk({tag, " imem_en"}, {31'd0, imem_en}, 32'd0);
    chk({tag, " halted"}, {31'd0, halted}, 32'd0);
    chk({tag, " inst_count"}, inst_count, 32'd0);
  endtask

  // Hold reset for a few cycles, check the reset state, release at posedge+1.
  task automatic do_reset(input string tag);
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stop_in = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_reset_state(tag);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  localparam logic [31:0] B = 32'h1000_0000;

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stop_in = 1'b0;
    imem_rdata = 32'h0;

    //            stall rd rpc   stop v  pc      inst     en h  cnt
    tbl[0]  = mk(1'b0, 0, 32'h0, 0, 0, 32'h00, 32'h0,    0, 0, 0);
    tbl[1]  = mk(1'b0, 0, 32'h0, 0, 0, 32'h00, 32'h0,    1, 0, 0);
    tbl[2]  = mk(1'b0, 0, 32'h0, 0, 1, 32'h00, B + 0,    1, 0, 0);
    tbl[3]  = mk(1'b0, 0, 32'h0, 0, 1, 32'h04, B + 1,    1, 0, 1);
    tbl[4]  = mk(1'b0, 0, 32'h0, 0, 1, 32'h08, B + 2,    1, 0, 2);
    tbl[5]  = mk(1'b0, 0, 32'h0, 0, 1, 32'h0C, B + 3,    1, 0, 3);
    tbl[6]  = mk(1'b1, 0, 32'h0, 0, 1, 32'h10, B + 4,    1, 0, 4);
    tbl[7]  = mk(1'b1, 0, 32'h0, 0, 1, 32'h10, B + 4,    0, 0, 4);
    tbl[8]  = mk(1'b1, 0, 32'h0, 0, 1, 32'h10, B + 4,    0, 0, 4);
    tbl[9]  = mk(1'b1, 0, 32'h0, 0, 1, 32'h10, B + 4,    0, 0, 4);
    tbl[10] = mk(1'b1, 0, 32'h0, 0, 1, 32'h10, B + 4,    0, 0, 4);
    tbl[11] = mk(1'b0, 0, 32'h0, 0, 1, 32'h10, B + 4,    1, 0, 4);
    tbl[12] = mk(1'b0, 0, 32'h0, 0, 1, 32'h14, B + 5,    1, 0, 5);
    tbl[13] = mk(1'b0, 0, 32'h0, 0, 1, 32'h18, B + 6,    1, 0, 6);
    tbl[14] = mk(1'b0, 0, 32'h0, 0, 1, 32'h1C, B + 7,    1, 0, 7);

    do_reset("reset0");

    // Streaming from reset, then a 5-cycle stall at pc 0x10 filling the buffer.
    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i], $sformatf("stream c%0d", i));
    end

    // Redirect with one entry buffered and one read returning.
    run_vec(mk(0, 1, 32'h0000_0203, 0, 1, 32'h20,  B + 8,     0, 0, 8),  "redir c15");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,     1, 0, 8),  "redir c16");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h200, B + 32'h80, 1, 0, 8), "redir c17");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h204, B + 32'h81, 1, 0, 9), "redir c18");

    // Redirect arriving together with stall while the buffer is full.
    run_vec(mk(1, 0, 32'h0,         0, 1, 32'h208, B + 32'h82, 1, 0, 10), "stredir c19");
    run_vec(mk(1, 0, 32'h0,         0, 1, 32'h208, B + 32'h82, 0, 0, 10), "stredir c20");
    run_vec(mk(1, 1, 32'h0000_0300, 0, 1, 32'h208, B + 32'h82, 0, 0, 10), "stredir c21");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,      1, 0, 10), "stredir c22");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h300, B + 32'hC0, 1, 0, 10), "stredir c23");

    // Stop on pc 0x40; later redirect must not restart fetch.
    run_vec(mk(0, 1, 32'h0000_003A, 0, 1, 32'h304, B + 32'hC1, 0, 0, 11), "stop c24");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,      1, 0, 11), "stop c25");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h38,  B + 32'h0E, 1, 0, 11), "stop c26");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h3C,  B + 32'h0F, 1, 0, 12), "stop c27");
    run_vec(mk(0, 0, 32'h0,         1, 1, 32'h40,  B + 32'h10, 1, 0, 13), "stop c28");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,      0, 1, 14), "stop c29");
    run_vec(mk(0, 1, 32'h0000_0100, 0, 0, 32'h0,   32'h0,      0, 1, 14), "stop c30");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,      0, 1, 14), "stop c31");
    run_vec(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,      0, 1, 14), "stop c32");

    // Reset clears halt; then rebuild state and reset mid-stall with the buffer full.
    do_reset("reset1");
    run_vec(mk(0, 0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0), "rst c0");
    run_vec(mk(0, 0, 32'h0, 0, 0, 32'h0,  32'h0, 1, 0, 0), "rst c1");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h0,  B + 0, 1, 0, 0), "rst c2");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h4,  B + 1, 1, 0, 1), "rst c3");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h8,  B + 2, 1, 0, 2), "rst c4");
    run_vec(mk(1, 0, 32'h0, 0, 1, 32'hC,  B + 3, 1, 0, 3), "rst c5");
    run_vec(mk(1, 0, 32'h0, 0, 1, 32'hC,  B + 3, 0, 0, 3), "rst c6");
    stall = 1'b1;
    #1;
    chk("full pre-reset valid_out", {31'd0, valid_out}, 32'd1);
    chk("full pre-reset pc_out", pc_out, 32'hC);
    chk("full pre-reset imem_en", {31'd0, imem_en}, 32'd0);
    chk("full pre-reset inst_count", inst_count, 32'd3);
    rstn = 1'b0;
    #1;
    chk_reset_state("async reset");
    @(posedge clk);
    #1;
    chk_reset_state("async reset held");
    rstn = 1'b1;
    run_vec(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0), "restart c0");
    run_vec(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0), "restart c1");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h0, B + 0, 1, 0, 0), "restart c2");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h4, B + 1, 1, 0, 1), "restart c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
